// File: rtl/mips_debug_controller.sv
// Serial debug front-end for the MIPS pipeline: loads program memory, runs or
// single-steps the CPU and reports PC plus cycle count over the UART.
module mips_debug_controller #(
    parameter int LEN          = 32,
    parameter int NB_PROG_ADDR = 5,
    parameter int NB_BYTE      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NB_BYTE-1:0]      i_rx_data,
    input  logic                    i_rx_valid,
    output logic [NB_BYTE-1:0]      o_tx_data,
    output logic                    o_tx_start,
    input  logic                    i_tx_done,
    output logic                    o_prog_we,
    output logic [NB_PROG_ADDR-1:0] o_prog_addr,
    output logic [LEN-1:0]          o_prog_data,
    output logic                    o_cpu_en,
    output logic                    o_cpu_rst_n,
    input  logic                    i_halt,
    input  logic [LEN-1:0]          i_pc,
    output logic [2:0]              o_state
);
    // Handshake: i_rx_valid, i_tx_done and o_tx_start are single-cycle pulses with
    // no back-pressure; a byte is consumed only if the current state wants it.

    localparam int BPW       = LEN / NB_BYTE;
    localparam int NB_BIDX   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int REP_BYTES = 2 * BPW;
    localparam int NB_RIDX   = $clog2(REP_BYTES);
    localparam int NB_WCNT   = NB_PROG_ADDR + 1;
    localparam int MAX_WORDS = 2 ** NB_PROG_ADDR;

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_NEXT = NB_BYTE'(8'h4E);
    localparam logic [NB_BYTE-1:0] CMD_END  = NB_BYTE'(8'h45);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_CNT  = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_RUN       = 3'd3,
        ST_STEP_WAIT = 3'd4,
        ST_STEP_EXEC = 3'd5,
        ST_REPORT    = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_cpu_rst_n;
    logic [LEN-1:0]          r_cnt;
    logic [LEN-1:0]          w_cnt_next;
    logic [NB_WCNT-1:0]      r_word_cnt;
    logic [NB_WCNT-1:0]      r_word_idx;
    logic [NB_WCNT-1:0]      w_word_cnt_sat;
    logic [NB_BIDX-1:0]      r_byte_idx;
    logic [LEN-1:0]          r_asm;
    logic                    r_prog_we;
    logic [NB_PROG_ADDR-1:0] r_prog_addr;
    logic [LEN-1:0]          r_prog_data;
    logic                    r_tx_start;
    logic [NB_BYTE-1:0]      r_tx_data;
    logic [NB_RIDX-1:0]      r_tx_idx;
    logic [2*LEN-1:0]        r_rep_shift;
    logic                    r_from_step;

    logic w_cpu_en;
    logic w_start_cpu;
    logic w_cnt_byte;
    logic w_data_byte;
    logic w_word_done;
    logic w_load_done;
    logic w_enter_report;
    logic w_tx_adv;
    logic w_tx_last;

    assign w_cpu_en    = (r_state == ST_RUN) || (r_state == ST_STEP_EXEC);
    assign w_start_cpu = (r_state == ST_IDLE) && i_rx_valid &&
                         ((i_rx_data == CMD_CONT) || (i_rx_data == CMD_STEP));
    assign w_cnt_byte  = (r_state == ST_LOAD_CNT) && i_rx_valid;
    // Once every word has been accepted the last write is still in flight; drop extra bytes.
    assign w_data_byte = (r_state == ST_LOAD_DATA) && i_rx_valid && (r_word_idx != r_word_cnt);
    assign w_word_done = w_data_byte && (r_byte_idx == NB_BIDX'(BPW - 1));
    assign w_load_done = (r_state == ST_LOAD_DATA) && r_prog_we && (r_word_idx == r_word_cnt);
    assign w_enter_report = ((r_state == ST_RUN) && i_halt) || (r_state == ST_STEP_EXEC);
    assign w_tx_adv    = (r_state == ST_REPORT) && i_tx_done;
    assign w_tx_last   = w_tx_adv && (r_tx_idx == NB_RIDX'(REP_BYTES - 1));
    assign w_cnt_next  = (w_cpu_en && (r_cnt != '1)) ? r_cnt + LEN'(1) : r_cnt;

    always_comb begin
        w_word_cnt_sat = NB_WCNT'(MAX_WORDS);
        if (32'(i_rx_data) <= 32'(MAX_WORDS)) begin
            w_word_cnt_sat = NB_WCNT'(i_rx_data);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD)      w_next_state = ST_LOAD_CNT;
                    else if (i_rx_data == CMD_CONT) w_next_state = ST_RUN;
                    else if (i_rx_data == CMD_STEP) w_next_state = ST_STEP_WAIT;
                end
            end
            ST_LOAD_CNT: begin
                if (i_rx_valid) begin
                    w_next_state = (i_rx_data == '0) ? ST_IDLE : ST_LOAD_DATA;
                end
            end
            ST_LOAD_DATA: begin
                if (w_load_done) w_next_state = ST_IDLE;
            end
            ST_RUN: begin
                if (i_halt) w_next_state = ST_REPORT;
            end
            ST_STEP_WAIT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_NEXT)     w_next_state = ST_STEP_EXEC;
                    else if (i_rx_data == CMD_END) w_next_state = ST_IDLE;
                end
            end
            ST_STEP_EXEC: begin
                w_next_state = ST_REPORT;
            end
            ST_REPORT: begin
                if (w_tx_last) begin
                    w_next_state = (r_from_step && !i_halt) ? ST_STEP_WAIT : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cpu_rst_n <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_start_cpu) begin
                r_cpu_rst_n <= 1'b1;
                r_cnt       <= '0;
            end else begin
                r_cnt <= w_cnt_next;
                if (w_next_state == ST_IDLE) r_cpu_rst_n <= 1'b0;
            end
        end
    end

    // Program load: big-endian byte assembly, write issued the cycle after the last byte.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_word_cnt  <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_asm       <= '0;
            r_prog_we   <= 1'b0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
        end else begin
            r_prog_we <= 1'b0;
            if (w_cnt_byte) begin
                r_word_cnt <= w_word_cnt_sat;
                r_word_idx <= '0;
                r_byte_idx <= '0;
            end else if (w_data_byte) begin
                r_asm <= {r_asm[LEN-NB_BYTE-1:0], i_rx_data};
                if (w_word_done) begin
                    r_byte_idx  <= '0;
                    r_prog_we   <= 1'b1;
                    r_prog_addr <= r_word_idx[NB_PROG_ADDR-1:0];
                    r_prog_data <= {r_asm[LEN-NB_BYTE-1:0], i_rx_data};
                    r_word_idx  <= r_word_idx + NB_WCNT'(1);
                end else begin
                    r_byte_idx <= r_byte_idx + NB_BIDX'(1);
                end
            end
        end
    end

    // Report: {PC, count} captured on entry and shifted out MSB first.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_tx_idx    <= '0;
            r_rep_shift <= '0;
            r_from_step <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            if (w_enter_report) begin
                r_rep_shift <= {i_pc, w_cnt_next};
                r_tx_data   <= i_pc[LEN-1 -: NB_BYTE];
                r_tx_start  <= 1'b1;
                r_tx_idx    <= '0;
                r_from_step <= (r_state == ST_STEP_EXEC);
            end else if (w_tx_adv && !w_tx_last) begin
                r_rep_shift <= {r_rep_shift[2*LEN-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
                r_tx_data   <= r_rep_shift[2*LEN-NB_BYTE-1 -: NB_BYTE];
                r_tx_start  <= 1'b1;
                r_tx_idx    <= r_tx_idx + NB_RIDX'(1);
            end
        end
    end

    assign o_state     = r_state;
    assign o_cpu_en    = w_cpu_en;
    assign o_cpu_rst_n = r_cpu_rst_n;
    assign o_prog_we   = r_prog_we;
    assign o_prog_addr = r_prog_addr;
    assign o_prog_data = r_prog_data;
    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;

endmodule

// File: tb/tb_mips_debug_controller.sv
// Directed bench for mips_debug_controller: command decode table plus load,
// run, step, drop and reset sequences against hand-computed expectations.
module tb_mips_debug_controller;
    localparam int LEN          = 32;
    localparam int NB_PROG_ADDR = 5;
    localparam int NB_BYTE      = 8;

    logic                    i_clk = 1'b0;
    logic                    i_rst;
    logic [NB_BYTE-1:0]      i_rx_data;
    logic                    i_rx_valid;
    logic [NB_BYTE-1:0]      o_tx_data;
    logic                    o_tx_start;
    logic                    i_tx_done;
    logic                    o_prog_we;
    logic [NB_PROG_ADDR-1:0] o_prog_addr;
    logic [LEN-1:0]          o_prog_data;
    logic                    o_cpu_en;
    logic                    o_cpu_rst_n;
    logic                    i_halt;
    logic [LEN-1:0]          i_pc;
    logic [2:0]              o_state;

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;
    int rep_starts = 0;
    logic [2:0] prev_state = 3'd0;
    logic       done_prev = 1'b0;

    logic [NB_BYTE-1:0]          got_tx_q[$];
    logic [NB_BYTE-1:0]          exp_tx_q[$];
    logic [NB_PROG_ADDR+LEN-1:0] got_wr_q[$];
    logic [NB_PROG_ADDR+LEN-1:0] exp_wr_q[$];

    typedef struct {
        logic [7:0] rx;
        logic [2:0] exp_state;
        logic       exp_rst_n;
        logic       exp_en;
    } dec_vec_t;
    dec_vec_t dec_tbl[7];

    mips_debug_controller #(
        .LEN(LEN), .NB_PROG_ADDR(NB_PROG_ADDR), .NB_BYTE(NB_BYTE)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_prog_we(o_prog_we), .o_prog_addr(o_prog_addr), .o_prog_data(o_prog_data),
        .o_cpu_en(o_cpu_en), .o_cpu_rst_n(o_cpu_rst_n),
        .i_halt(i_halt), .i_pc(i_pc), .o_state(o_state)
    );

    // Clock and watchdog
    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic send_rx(input logic [7:0] b);
        @(posedge i_clk); #1;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge i_clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_rx_valid = 1'b0; i_halt = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (o_state !== st && n < budget) begin
            @(posedge i_clk); #1;
            n++;
        end
        check(name, o_state, st);
    endtask

    task automatic set_exp_report(input logic [31:0] pc, input logic [31:0] cnt);
        exp_tx_q.delete();
        for (int i = 0; i < 4; i++) exp_tx_q.push_back(pc[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) exp_tx_q.push_back(cnt[31-8*i -: 8]);
    endtask

    task automatic check_tx_q(input string name);
        check({name, "_count"}, got_tx_q.size(), exp_tx_q.size());
        for (int i = 0; i < exp_tx_q.size() && i < got_tx_q.size(); i++)
            check(name, got_tx_q[i], exp_tx_q[i]);
    endtask

    task automatic check_wr_q(input string name);
        check({name, "_count"}, got_wr_q.size(), exp_wr_q.size());
        for (int i = 0; i < exp_wr_q.size() && i < got_wr_q.size(); i++)
            check(name, got_wr_q[i], exp_wr_q[i]);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_state"}, o_state, 3'd0);
        check({name, "_rst_n"}, o_cpu_rst_n, 1'b0);
        check({name, "_en"}, o_cpu_en, 1'b0);
        check({name, "_we"}, o_prog_we, 1'b0);
        check({name, "_addr"}, o_prog_addr, '0);
        check({name, "_data"}, o_prog_data, '0);
        check({name, "_tx_start"}, o_tx_start, 1'b0);
        check({name, "_tx_data"}, o_tx_data, '0);
    endtask

    // Transmitter model: i_tx_done three cycles after each start
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_tx_start === 1'b1) begin
                repeat (3) @(posedge i_clk);
                #1 i_tx_done = 1'b1;
                @(posedge i_clk);
                #1 i_tx_done = 1'b0;
            end
        end
    end

    // Monitor: capture writes and tx bytes, check start timing
    always @(negedge i_clk) begin
        if (i_rst === 1'b1) begin
            if (o_prog_we === 1'b1) got_wr_q.push_back({o_prog_addr, o_prog_data});
            if (o_cpu_en === 1'b1) en_cnt++;
            if (o_tx_start === 1'b1) begin
                got_tx_q.push_back(o_tx_data);
                if (rep_starts == 0) check("tx_first_start_prev_state_not_report", prev_state == 3'd6, 1'b0);
                else check("tx_start_after_done", done_prev, 1'b1);
            end
        end
        if (o_state !== 3'd6) rep_starts = 0;
        else if (o_tx_start === 1'b1) rep_starts++;
        done_prev  = i_tx_done;
        prev_state = o_state;
    end

    initial begin
        int n;
        logic [31:0] w;

        dec_tbl[0] = '{8'h4E, 3'd0, 1'b0, 1'b0};
        dec_tbl[1] = '{8'h4C, 3'd1, 1'b0, 1'b0};
        dec_tbl[2] = '{8'h43, 3'd3, 1'b1, 1'b1};
        dec_tbl[3] = '{8'h53, 3'd4, 1'b1, 1'b0};
        dec_tbl[4] = '{8'h45, 3'd0, 1'b0, 1'b0};
        dec_tbl[5] = '{8'h00, 3'd0, 1'b0, 1'b0};
        dec_tbl[6] = '{8'h6C, 3'd0, 1'b0, 1'b0};

        i_rst = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0; i_halt = 1'b0; i_pc = '0;
        repeat (3) @(posedge i_clk);
        #1 check_reset_outputs("reset");
        i_rst = 1'b1;

        // Command decode table from IDLE
        for (int i = 0; i < 7; i++) begin
            do_reset();
            send_rx(dec_tbl[i].rx);
            check($sformatf("decode_%0h_state", dec_tbl[i].rx), o_state, dec_tbl[i].exp_state);
            check($sformatf("decode_%0h_rst_n", dec_tbl[i].rx), o_cpu_rst_n, dec_tbl[i].exp_rst_n);
            check($sformatf("decode_%0h_en", dec_tbl[i].rx), o_cpu_en, dec_tbl[i].exp_en);
        end

        // Two-word load
        do_reset();
        got_wr_q.delete(); exp_wr_q.delete();
        exp_wr_q.push_back({5'd0, 32'h20010005});
        exp_wr_q.push_back({5'd1, 32'h00000000});
        send_rx(8'h4C); send_rx(8'h02);
        send_rx(8'h20); send_rx(8'h01); send_rx(8'h00); send_rx(8'h05);
        send_rx(8'h00); send_rx(8'h00); send_rx(8'h00); send_rx(8'h00);
        repeat (3) @(posedge i_clk); #1;
        check_wr_q("load2_write");
        check("load2_state", o_state, 3'd0);

        // Zero-length load
        got_wr_q.delete();
        send_rx(8'h4C); send_rx(8'h00);
        check("load0_state", o_state, 3'd0);
        repeat (3) @(posedge i_clk); #1;
        check("load0_writes", got_wr_q.size(), 0);

        // Oversized count saturates to 32 words
        got_wr_q.delete(); exp_wr_q.delete();
        send_rx(8'h4C); send_rx(8'h40);
        for (int k = 0; k < 32; k++) begin
            w = {8'(k), 8'hA5, 8'(k) ^ 8'h3C, 8'h5A};
            exp_wr_q.push_back({5'(k), w});
            for (int b = 0; b < 4; b++) send_rx(w[31-8*b -: 8]);
        end
        repeat (3) @(posedge i_clk); #1;
        check_wr_q("load64_write");
        check("load64_state", o_state, 3'd0);

        // Free run with bytes dropped in RUN and REPORT
        got_tx_q.delete(); en_cnt = 0;
        i_pc = 32'h00000024;
        send_rx(8'h43);
        for (int c = 1; c < 10; c++) begin
            if (c == 3) begin i_rx_data = 8'h53; i_rx_valid = 1'b1; end
            else i_rx_valid = 1'b0;
            if (c == 5) begin
                check("run_state", o_state, 3'd3);
                check("run_rst_n", o_cpu_rst_n, 1'b1);
            end
            @(posedge i_clk); #1;
        end
        i_rx_valid = 1'b0;
        i_halt = 1'b1;
        @(posedge i_clk); #1;
        check("run_halt_en_off", o_cpu_en, 1'b0);
        check("run_halt_state", o_state, 3'd6);
        n = 0;
        while (got_tx_q.size() < 4 && n < 100) begin
            i_rx_data = 8'h4C; i_rx_valid = 1'b1;
            @(posedge i_clk); #1;
            n++;
        end
        i_rx_valid = 1'b0;
        check("run_report_still", o_state, 3'd6);
        wait_state(3'd0, 200, "run_back_idle");
        i_halt = 1'b0;
        set_exp_report(32'h00000024, 32'd10);
        check_tx_q("run_report");
        check("run_en_cycles", en_cnt, 10);
        check("run_idle_rst_n", o_cpu_rst_n, 1'b0);

        // Single step twice, then end
        got_tx_q.delete(); en_cnt = 0;
        i_pc = 32'h4;
        send_rx(8'h53);
        check("step_wait_state", o_state, 3'd4);
        check("step_wait_en", o_cpu_en, 1'b0);
        check("step_wait_rst_n", o_cpu_rst_n, 1'b1);
        send_rx(8'h4E);
        check("step_exec_state", o_state, 3'd5);
        check("step_exec_en", o_cpu_en, 1'b1);
        wait_state(3'd4, 200, "step1_back_wait");
        check("step1_en_cycles", en_cnt, 1);
        set_exp_report(32'h4, 32'd1);
        check_tx_q("step1_report");
        got_tx_q.delete();
        i_pc = 32'h8;
        send_rx(8'h4E);
        wait_state(3'd4, 200, "step2_back_wait");
        check("step2_en_cycles", en_cnt, 2);
        set_exp_report(32'h8, 32'd2);
        check_tx_q("step2_report");
        send_rx(8'h45);
        check("step_end_state", o_state, 3'd0);
        check("step_end_rst_n", o_cpu_rst_n, 1'b0);

        // Reset after two bytes of the second word
        got_wr_q.delete(); exp_wr_q.delete();
        exp_wr_q.push_back({5'd0, 32'h11223344});
        send_rx(8'h4C); send_rx(8'h02);
        send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
        send_rx(8'h55); send_rx(8'h66);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check_reset_outputs("midload_reset");
        i_rst = 1'b1;
        send_rx(8'h77); send_rx(8'h88);
        repeat (3) @(posedge i_clk); #1;
        check_wr_q("midload_write");
        check("midload_state", o_state, 3'd0);

        // Reset in the middle of a report
        got_tx_q.delete();
        i_pc = 32'h100;
        send_rx(8'h53); send_rx(8'h4E);
        n = 0;
        while (got_tx_q.size() < 2 && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("midrep_two_bytes", got_tx_q.size(), 2);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check_reset_outputs("midrep_reset");
        i_rst = 1'b1;
        repeat (30) @(posedge i_clk); #1;
        check("midrep_no_more_starts", got_tx_q.size(), 2);
        check("midrep_state", o_state, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_debug_controller.md
MIPS_DEBUG_CONTROLLER -- requirements
Module: mips_debug_controller

Interface
REQ-001 SHALL have parameter LEN, default 32: instruction/PC/counter width.
REQ-002 SHALL have parameter NB_PROG_ADDR, default 5: program-memory address width (32 words).
REQ-003 SHALL have parameter NB_BYTE, default 8: serial byte width.
REQ-004 i_clk  in  1: single clock; all logic on rising edge.
REQ-005 i_rst  in  1: reset, synchronous, active-low.
REQ-006 i_rx_data  in  NB_BYTE: received command/data byte.
REQ-007 i_rx_valid  in  1: one-cycle pulse, i_rx_data valid.
REQ-008 o_tx_data  out  NB_BYTE: byte to transmit.
REQ-009 o_tx_start  out  1: one-cycle pulse, start transmitting o_tx_data.
REQ-010 i_tx_done  in  1: one-cycle pulse, transmitter finished previous byte.
REQ-011 o_prog_we  out  1: program-memory write enable.
REQ-012 o_prog_addr  out  NB_PROG_ADDR: program-memory write address.
REQ-013 o_prog_data  out  LEN: program-memory write word.
REQ-014 o_cpu_en  out  1: CPU pipeline clock enable.
REQ-015 o_cpu_rst_n  out  1: CPU reset, active-low.
REQ-016 i_halt  in  1: HALT instruction reached write-back (level).
REQ-017 i_pc  in  LEN: current CPU PC.
REQ-018 o_state  out  3: IDLE=0, LOAD_CNT=1, LOAD_DATA=2, RUN=3, STEP_WAIT=4, STEP_EXEC=5, REPORT=6.

Function
REQ-019 IDLE: o_cpu_rst_n=0, o_cpu_en=0; rx byte 0x4C ('L') -> LOAD_CNT, 0x43 ('C') -> RUN, 0x53 ('S') -> STEP_WAIT; any other byte ignored.
REQ-020 Entry to RUN or STEP_WAIT from IDLE SHALL clear cycle counter and set o_cpu_rst_n=1 from the next cycle.
REQ-021 LOAD_CNT: next rx byte = word count W; W=0 -> IDLE, no writes; W>2**NB_PROG_ADDR saturates to 2**NB_PROG_ADDR; else -> LOAD_DATA.
REQ-022 LOAD_DATA: bytes assembled big-endian (first byte = bits LEN-1..LEN-8); word k (k=0..W-1) written to address k.
REQ-023 Write SHALL occur on the cycle after the 4th byte of a word is accepted: o_prog_we=1 for exactly one cycle with o_prog_addr/o_prog_data stable that cycle.
REQ-024 After write of word W-1, next state SHALL be IDLE; o_prog_we=0 at all other times.
REQ-025 RUN: o_cpu_en=1 every cycle until i_halt sampled 1; counter +1 per enabled cycle; on halt o_cpu_en=0 next cycle, -> REPORT.
REQ-026 Cycle counter LEN bits, saturating at all-ones (no wrap).
REQ-027 STEP_WAIT: o_cpu_en=0; rx 0x4E ('N') -> STEP_EXEC; rx 0x45 ('E') -> IDLE; others ignored.
REQ-028 STEP_EXEC: o_cpu_en=1 for exactly one cycle, counter +1, then REPORT.
REQ-029 REPORT: snapshot i_pc and counter on entry; send 8 bytes: PC MSB-first, then counter MSB-first.
REQ-030 First o_tx_start on cycle after entry; each subsequent o_tx_start one cycle after i_tx_done; o_tx_data held until next start.
REQ-031 After 8th byte's i_tx_done: -> STEP_WAIT if reached from STEP_EXEC and i_halt=0; else -> IDLE.
REQ-032 rx bytes arriving in RUN, STEP_EXEC, REPORT SHALL be dropped, no state effect.
REQ-033 i_tx_done outside REPORT SHALL be ignored.
REQ-034 i_rx_valid and i_tx_done same cycle in REPORT: both processed independently (rx dropped, tx advances).

Reset
REQ-035 i_rst=0 at a rising edge SHALL force: state IDLE, o_cpu_rst_n=0, o_cpu_en=0, o_prog_we=0, o_prog_addr=0, o_prog_data=0, o_tx_start=0, o_tx_data=0, counter=0, byte/word indices=0.
REQ-036 Reset mid-load SHALL discard partial word; words already written remain in memory; mid-REPORT SHALL abort transmission with no further o_tx_start.

Verification
REQ-037 Load: rx 0x4C,0x02, 20 01 00 05, 00 00 00 00 -> o_prog_we pulses: addr0=0x20010005, addr1=0x00000000; o_state returns 0.
REQ-038 Run: rx 0x43, i_halt raised after 10 enabled cycles, i_pc=0x00000024 -> tx bytes 00 00 00 24 00 00 00 0A, each start one cycle after i_tx_done.
REQ-039 Step: rx 0x53, 0x4E twice, i_pc=0x4 then 0x8 -> exactly one o_cpu_en cycle per 'N'; reports end ..04/..01 and ..08/..02; rx 0x45 -> IDLE, o_cpu_rst_n=0.
REQ-040 Boundaries: W=0 -> no write, IDLE; W=0x40 -> exactly 32 writes, addr 0..31; rx 0x4E in IDLE ignored.
REQ-041 Reset: i_rst=0 after 2 bytes of a word in LOAD_DATA -> all outputs reset values next cycle, no write of that word.
REQ-042 Drop: rx bytes during RUN and REPORT -> no state change, report bytes unchanged.
